// File: rtl/pipe_in_pkg.sv
// Shared widths, default geometry and the entry type for the Pipe In FIFO.
package pipe_in_pkg;

   localparam int HOST_W          = 32;
   localparam int ENTRY_W         = 64;
   localparam int DEPTH_LOG2_DEF  = 9;
   localparam int BLOCK_WORDS_DEF = 256;
   localparam int DROP_CNT_W      = 16;

   typedef logic [ENTRY_W-1:0] entry_t;

   // The first host word of a pair lands in the low half.
   function automatic entry_t pack_entry(input logic [HOST_W-1:0] hi_word,
                                         input logic [HOST_W-1:0] lo_word);
      return {hi_word, lo_word};
   endfunction

endpackage

// File: rtl/pipe_in_fifo_ram.sv
// Simple dual-port entry RAM: one write port, one registered read port.
module pipe_in_fifo_ram
   import pipe_in_pkg::*;
#(
   parameter int ADDR_W = DEPTH_LOG2_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  entry_t            wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output entry_t            rd_data
);

   entry_t mem [0:(1 << ADDR_W)-1];
   entry_t rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read-first: a same-address write at full returns the old entry.
   // Output register holds its value between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/pipe_in_fifo64.sv
// Packs 32-bit host words into 64-bit entries and buffers them in a block-RAM FIFO.
// Optional drop counter enabled by defining PIPE_IN_FIFO_DROP_CNT_EN.
module pipe_in_fifo64
   import pipe_in_pkg::*;
#(
   parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
   parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ep_write,
   input  logic [HOST_W-1:0]     ep_data,
   output logic                  ep_ready,
   input  logic                  pipe_in_read,
   output logic [ENTRY_W-1:0]    pipe_in_data,
   output logic                  pipe_in_valid,
   output logic                  pipe_in_empty,
   output logic                  pipe_in_full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic                  underflow,
   output logic [DROP_CNT_W-1:0] drop_count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LVL_W = DEPTH_LOG2 + 1;

   logic                  half_q, half_d;
   logic [HOST_W-1:0]     hold_q, hold_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  valid_q, valid_d;
   logic                  ready_q, ready_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic        is_empty;
   logic        is_full;
   logic        commit;
   logic        pop;
   logic        accept;
   logic        drop;
   logic [31:0] space_words;
   logic [31:0] need_words;

   assign is_empty = (level_q == '0);
   assign is_full  = (level_q == LVL_W'(DEPTH));
   assign commit   = ep_write & half_q;
   assign pop      = pipe_in_read & ~is_empty;
   // A full FIFO still takes an entry when the same cycle frees a slot.
   assign accept   = commit & (~is_full | pop);
   assign drop     = commit & is_full & ~pop;

   always_comb begin
      half_d      = half_q;
      hold_d      = hold_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      valid_d     = pop;
      overflow_d  = overflow_q | drop;
      underflow_d = underflow_q | (pipe_in_read & is_empty);

      if (ep_write) begin
         half_d = ~half_q;
         if (!half_q) begin
            hold_d = ep_data;
         end
      end

      if (accept) begin
         wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end

      unique case ({accept, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Room for a whole host block, counting the pending half word.
   always_comb begin
      space_words = (32'(DEPTH) - 32'(level_q)) << 1;
      need_words  = 32'(BLOCK_WORDS) + 32'(half_q);
      ready_d     = (space_words >= need_words);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         half_q      <= 1'b0;
         hold_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         valid_q     <= 1'b0;
         ready_q     <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         half_q      <= half_d;
         hold_q      <= hold_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         valid_q     <= valid_d;
         ready_q     <= ready_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   pipe_in_fifo_ram #(
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (accept),
      .wr_addr (wr_ptr_q),
      .wr_data (pack_entry(ep_data, hold_q)),
      .rd_en   (pop),
      .rd_addr (rd_ptr_q),
      .rd_data (pipe_in_data)
   );

`ifdef PIPE_IN_FIFO_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count = '0;
`endif

   assign ep_ready      = ready_q;
   assign pipe_in_valid = valid_q;
   assign pipe_in_empty = is_empty;
   assign pipe_in_full  = is_full;
   assign level         = level_q;
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;

endmodule

// File: tb/tb_pipe_in_fifo64.sv
// Directed vector table plus hand-written streaming, throttle and full/overflow sequences.
module tb_pipe_in_fifo64;
   import pipe_in_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ep_write;
   logic [31:0] ep_data;
   logic        ep_ready;
   logic        pipe_in_read;
   logic [63:0] pipe_in_data;
   logic        pipe_in_valid;
   logic        pipe_in_empty;
   logic        pipe_in_full;
   logic [9:0]  level;
   logic        overflow;
   logic        underflow;
   logic [15:0] drop_count;

   pipe_in_fifo64 dut (
      .clk           (clk),
      .reset         (reset),
      .ep_write      (ep_write),
      .ep_data       (ep_data),
      .ep_ready      (ep_ready),
      .pipe_in_read  (pipe_in_read),
      .pipe_in_data  (pipe_in_data),
      .pipe_in_valid (pipe_in_valid),
      .pipe_in_empty (pipe_in_empty),
      .pipe_in_full  (pipe_in_full),
      .level         (level),
      .overflow      (overflow),
      .underflow     (underflow),
      .drop_count    (drop_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic        rst;
      logic        wr;
      logic [31:0] data;
      logic        rd;
      logic        empty;
      logic        valid;
      logic [63:0] dout;
      logic [9:0]  lvl;
      logic        unf;
      logic        rdy;
   } vec_t;

   vec_t vecs [13];

   function automatic vec_t mk(input logic rst, input logic wr, input logic [31:0] data,
                               input logic rd, input logic empty, input logic valid,
                               input logic [63:0] dout, input logic [9:0] lvl,
                               input logic unf, input logic rdy);
      vec_t v;
      v.rst = rst; v.wr = wr; v.data = data; v.rd = rd;
      v.empty = empty; v.valid = valid; v.dout = dout; v.lvl = lvl;
      v.unf = unf; v.rdy = rdy;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; ep_write = 1'b0; pipe_in_read = 1'b0; ep_data = '0;
      step();
      reset = 1'b0;
   endtask

   function automatic logic [63:0] stream_entry(input int k);
      return {32'(2 * k + 1), 32'(2 * k)};
   endfunction

   function automatic logic [63:0] fill_entry(input int k);
      return {32'h1000_0000 + 32'(2 * k + 1), 32'h1000_0000 + 32'(2 * k)};
   endfunction

   initial begin
      int wcnt;
      int rcnt;
      int d;
      logic wr_now;
      logic [31:0] thr;
      logic [63:0] exp_e;

      reset = 1'b1; ep_write = 1'b0; ep_data = '0; pipe_in_read = 1'b0;

      vecs[0]  = mk(1, 0, 32'h0, 0, 1, 0, 64'h0,                0, 0, 0);
      vecs[1]  = mk(0, 0, 32'h0, 0, 1, 0, 64'h0,                0, 0, 1);
      vecs[2]  = mk(0, 1, 32'h1, 0, 1, 0, 64'h0,                0, 0, 1);
      vecs[3]  = mk(0, 1, 32'h1, 0, 0, 0, 64'h0,                1, 0, 1);
      vecs[4]  = mk(0, 0, 32'h0, 1, 1, 1, 64'h0000000100000001, 0, 0, 1);
      vecs[5]  = mk(0, 0, 32'h0, 0, 1, 0, 64'h0000000100000001, 0, 0, 1);
      vecs[6]  = mk(0, 0, 32'h0, 1, 1, 0, 64'h0000000100000001, 0, 1, 1);
      vecs[7]  = mk(0, 1, 32'h5, 0, 1, 0, 64'h0000000100000001, 0, 1, 1);
      vecs[8]  = mk(1, 0, 32'h0, 0, 1, 0, 64'h0,                0, 0, 0);
      vecs[9]  = mk(0, 1, 32'hA, 0, 1, 0, 64'h0,                0, 0, 1);
      vecs[10] = mk(0, 1, 32'hB, 0, 0, 0, 64'h0,                1, 0, 1);
      vecs[11] = mk(0, 0, 32'h0, 1, 1, 1, 64'h0000000B0000000A, 0, 0, 1);
      vecs[12] = mk(0, 0, 32'h0, 0, 1, 0, 64'h0000000B0000000A, 0, 0, 1);

      for (int i = 0; i < 13; i++) begin
         reset = vecs[i].rst; ep_write = vecs[i].wr; ep_data = vecs[i].data;
         pipe_in_read = vecs[i].rd;
         step();
         check($sformatf("vec%0d.empty", i), 64'(pipe_in_empty), 64'(vecs[i].empty));
         check($sformatf("vec%0d.valid", i), 64'(pipe_in_valid), 64'(vecs[i].valid));
         check($sformatf("vec%0d.data", i), pipe_in_data, vecs[i].dout);
         check($sformatf("vec%0d.level", i), 64'(level), 64'(vecs[i].lvl));
         check($sformatf("vec%0d.underflow", i), 64'(underflow), 64'(vecs[i].unf));
         check($sformatf("vec%0d.ep_ready", i), 64'(ep_ready), 64'(vecs[i].rdy));
         check($sformatf("vec%0d.full", i), 64'(pipe_in_full), 64'h0);
      end
      reset = 1'b0; ep_write = 1'b0; pipe_in_read = 1'b0;

      // Streaming with throttled pops
      do_reset();
      thr = 32'hAAAAAAAA;
      wcnt = 0; rcnt = 0;
      for (int cyc = 0; cyc < 5000 && (wcnt < 1024 || rcnt < 512); cyc++) begin
         wr_now = (wcnt < 1024);
         ep_write = wr_now;
         ep_data = 32'(wcnt);
         pipe_in_read = thr[cyc % 32] && !pipe_in_empty;
         step();
         if (wr_now) wcnt++;
         if (pipe_in_valid) begin
            check($sformatf("stream.entry%0d", rcnt), pipe_in_data, stream_entry(rcnt));
            rcnt++;
         end
      end
      ep_write = 1'b0; pipe_in_read = 1'b0;
      check("stream.count", 64'(rcnt), 64'd512);
      check("stream.overflow", 64'(overflow), 64'h0);
      check("stream.underflow", 64'(underflow), 64'h0);

      // ep_ready around level 384/385
      do_reset();
      for (int w = 0; w < 768; w++) begin
         ep_write = 1'b1; ep_data = 32'h1000_0000 + 32'(w);
         step();
      end
      ep_write = 1'b0;
      step(); step();
      check("ready384.level", 64'(level), 64'd384);
      check("ready384.ep_ready", 64'(ep_ready), 64'h1);
      ep_write = 1'b1; ep_data = 32'h2000_0000; step();
      ep_data = 32'h2000_0001; step();
      ep_write = 1'b0; step();
      check("ready385.level", 64'(level), 64'd385);
      check("ready385.ep_ready", 64'(ep_ready), 64'h0);
      pipe_in_read = 1'b1; step(); pipe_in_read = 1'b0;
      check("readylag.level", 64'(level), 64'd384);
      check("readylag.ep_ready", 64'(ep_ready), 64'h0);
      check("readylag.data", pipe_in_data, fill_entry(0));
      step();
      check("readyback.ep_ready", 64'(ep_ready), 64'h1);

      // Fill, commit+pop at full, overflow, drain
      do_reset();
      for (int w = 0; w < 1024; w++) begin
         ep_write = 1'b1; ep_data = 32'h1000_0000 + 32'(w);
         step();
      end
      ep_write = 1'b0; step();
      check("fill.level", 64'(level), 64'd512);
      check("fill.full", 64'(pipe_in_full), 64'h1);
      check("fill.overflow", 64'(overflow), 64'h0);
      check("fill.ep_ready", 64'(ep_ready), 64'h0);

      ep_write = 1'b1; ep_data = 32'hC0DE_0000; step();
      ep_data = 32'hC0DE_0001; pipe_in_read = 1'b1; step();
      ep_write = 1'b0; pipe_in_read = 1'b0;
      check("fullpop.level", 64'(level), 64'd512);
      check("fullpop.overflow", 64'(overflow), 64'h0);
      check("fullpop.valid", 64'(pipe_in_valid), 64'h1);
      check("fullpop.data", pipe_in_data, fill_entry(0));

      ep_write = 1'b1; ep_data = 32'hDEAD_0000; step();
      ep_data = 32'hDEAD_0001; step();
      ep_write = 1'b0; step();
      check("drop.level", 64'(level), 64'd512);
      check("drop.full", 64'(pipe_in_full), 64'h1);
      check("drop.overflow", 64'(overflow), 64'h1);
`ifdef PIPE_IN_FIFO_DROP_CNT_EN
      check("drop.drop_count", 64'(drop_count), 64'd1);
`else
      check("drop.drop_count", 64'(drop_count), 64'd0);
`endif

      d = 0;
      for (int cyc = 0; cyc < 530; cyc++) begin
         pipe_in_read = !pipe_in_empty;
         step();
         if (pipe_in_valid) begin
            exp_e = (d < 511) ? fill_entry(d + 1) : 64'hC0DE0001_C0DE0000;
            check($sformatf("drain.entry%0d", d), pipe_in_data, exp_e);
            d++;
         end
      end
      pipe_in_read = 1'b0;
      check("drain.count", 64'(d), 64'd512);
      check("drain.empty", 64'(pipe_in_empty), 64'h1);
      check("drain.level", 64'(level), 64'd0);
      check("drain.underflow", 64'(underflow), 64'h0);
      check("drain.overflow", 64'(overflow), 64'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_in_fifo64.md
# pipe_in_fifo64

Single-clock buffer between the host Pipe In endpoint and the Pipe In checker. Accepts 32-bit host words, packs consecutive pairs into 64-bit entries, stores them in a block-RAM FIFO, and presents them through a read/valid/empty interface to the downstream consumer. It also generates the block-throttle ready flag returned to the host endpoint and flags overflow and underflow.

## Interface
- DEPTH_LOG2, 9: log2 of FIFO depth in 64-bit entries (512).
- BLOCK_WORDS, 256: host block size in 32-bit words; gates `ep_ready`.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ep_write  in  1  host word strobe.
- ep_data  in  32  host word.
- ep_ready  out  1  space for one full host block.
- pipe_in_read  in  1  consumer pop request.
- pipe_in_data  out  64  popped entry.
- pipe_in_valid  out  1  `pipe_in_data` valid this cycle.
- pipe_in_empty  out  1  no committed entries.
- pipe_in_full  out  1  level == 2^DEPTH_LOG2.
- level  out  DEPTH_LOG2+1  committed entry count.
- overflow  out  1  sticky: a completed entry was dropped.
- underflow  out  1  sticky: pop while empty.
- drop_count  out  16  dropped entries (see Configuration).

## Operation
- Packing: a `half` flag toggles on every `ep_write`. When `half`=0, `ep_data` goes to the hold register, which holds bits [31:0]. When `half`=1, `{ep_data, hold}` is committed at `wr_ptr`.
- Commit when not full, or when full and a pop is accepted in the same cycle: the RAM is written, `wr_ptr` increments (mod depth), and the entry counts toward `level`.
- Commit when full with no pop: the entry is dropped, `overflow` is set, the pointer is unchanged, and `half` still toggles so word alignment is preserved.
- Pop: `pipe_in_read` with `pipe_in_empty`=0 reads at `rd_ptr`, and `rd_ptr` increments. `pipe_in_read` with `pipe_in_empty`=1 is ignored and sets `underflow`.
- `level` update: +1 on commit only, −1 on pop only, unchanged when both occur. Pointers wrap naturally.
- `ep_ready` = (2^DEPTH_LOG2 − level)·2 ≥ BLOCK_WORDS + (`half` ? 1 : 0), registered.
- Reset values:
  - `pipe_in_empty`=1.
  - `pipe_in_full`=0, `pipe_in_valid`=0, `pipe_in_data`=0, `level`=0.
  - `overflow`=0, `underflow`=0, `drop_count`=0.
  - `ep_ready`=0, then 1 from the first cycle after reset.
  - `half`=0, hold=0.
- Reset mid-operation: all contents are discarded, including a pending half word. RAM contents are not cleared.

## Timing
- Commit in cycle N: `level`, `pipe_in_empty` and `pipe_in_full` are updated at the N+1 edge.
- Pop accepted in cycle N: `pipe_in_data` and `pipe_in_valid`=1 at N+1. `pipe_in_valid` is a single-cycle pulse per pop.
- Back-to-back pops yield back-to-back valid data. The minimum first-write-to-data latency is 3 cycles: second word N, pop N+1, data N+2.
- `pipe_in_data` holds its last value when `pipe_in_valid`=0.
- `ep_ready` lags `level` by one cycle.

## Configuration
- PIPE_IN_FIFO_DROP_CNT_EN:
  - When defined, `drop_count` increments on each dropped entry and saturates at 0xFFFF.
  - When undefined, `drop_count` is tied to 0 and no counter logic is built.
  - The `overflow` sticky is present either way.

## Structure
- Package `pipe_in_pkg` holds:
  - `HOST_W`=32 and `ENTRY_W`=64.
  - Default `DEPTH_LOG2` and `BLOCK_WORDS`.
  - A typedef for the 64-bit entry.
- Sub-module `pipe_in_fifo_ram`: simple dual-port RAM, one write port, registered read port, `ENTRY_W` × 2^DEPTH_LOG2. It infers block RAM.
- Pointers, level, packing, flags and the counter live in the top.

## Test plan
- Reset, then write 0x00000001 and 0x00000001, then pop:
  - `pipe_in_empty` falls one cycle after the second write.
  - The pop returns 0x0000000100000001 with `pipe_in_valid` one cycle after `pipe_in_read`.
- Stream 1024 host words with an incrementing count in each half, popping continuously with throttle 0xAAAAAAAA. Expect 512 valid entries in order and no overflow or underflow.
- Fill to 512 entries, then write 2 more words with no pop:
  - `pipe_in_full`=1, `overflow`=1, `drop_count`=1 (macro defined), `level` stays 512.
  - Drain: all 512 original entries return intact.
- At full, commit and pop in the same cycle: the entry is accepted, `level` stays 512, `overflow` stays 0.
- Pop while empty: `underflow`=1, `pipe_in_valid` stays 0, `level` stays 0.
- Write one word, assert reset, then write 0xA and 0xB: the first entry popped is 0x0000000B0000000A.
- `ep_ready`: at `level` = 512 − 128 = 384 with `half`=0, `ep_ready`=1. At `level`=385, `ep_ready` deasserts one cycle later.
